// File: rtl/locked_adder_pkg.sv
// Shared definitions for the key-locked pipelined adder/subtractor:
// key-loader FSM states, the default key-gate type pattern and the
// key-gate to sum-bit mapping.
package locked_adder_pkg;

  // Upper bound on the key length that the default-pattern helper can build.
  localparam int MAX_KEY_BITS = 1024;

  // Key-loader FSM states.
  typedef enum logic {
    LOAD  = 1'b0,
    ARMED = 1'b1
  } key_state_e;

  // Default gate-type pattern: repeated 2'b10, so odd key bits are AND-type
  // and even key bits are OR-type. Callers keep the low key_bits bits.
  function automatic logic [MAX_KEY_BITS-1:0] key_type_default(input int key_bits);
    logic [MAX_KEY_BITS-1:0] pattern;
    pattern = '0;
    for (int i = 1; i < key_bits && i < MAX_KEY_BITS; i += 2) begin
      pattern[i] = 1'b1;
    end
    return pattern;
  endfunction

  // Sum bit corrupted by key gate i when the result is width+1 bits wide.
  function automatic int tgt(input int i, input int width);
    return i % (width + 1);
  endfunction

endpackage

// File: rtl/locked_pipelined_addsub_key_loader.sv
// Serial key loader: shifts the key in LSB first, counts loaded bits and
// freezes the key once all KEY_BITS bits have arrived.
module key_loader
  import locked_adder_pkg::*;
#(
  parameter int KEY_BITS = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                key_sin,
  input  logic                key_shift_en,
  input  logic                key_clear,
  output logic [KEY_BITS-1:0] key_reg,
  output logic                key_armed
);

  localparam int CNT_W = $clog2(KEY_BITS);

  key_state_e       state;
  logic [CNT_W-1:0] cnt;

  // Shift register, bit counter and LOAD/ARMED state; clear beats a shift.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: every register here is assigned with <= so all of them update
    // from the values held before the edge, whatever the statement order.
    if (!rst_n) begin
      state   <= LOAD;
      key_reg <= '0;
      cnt     <= '0;
    end else if (key_clear) begin
      state   <= LOAD;
      key_reg <= '0;
      cnt     <= '0;
    end else if (state == LOAD && key_shift_en) begin
      key_reg <= {key_sin, key_reg[KEY_BITS-1:1]};
      cnt     <= cnt + CNT_W'(1);
      if (cnt == CNT_W'(KEY_BITS - 1)) begin
        state <= ARMED;
      end
    end
  end

  assign key_armed = (state == ARMED);

endmodule

// File: rtl/locked_pipelined_addsub.sv
// Key-locked adder/subtractor with a STAGES-deep valid/ready pipeline.
// Operands are accepted only once the key is armed; the key gates are applied
// as the result enters the last register stage.
module locked_pipelined_addsub
  import locked_adder_pkg::*;
#(
  parameter int                  WIDTH    = 32,
  parameter int                  KEY_BITS = 64,
  parameter logic [KEY_BITS-1:0] KEY_TYPE = KEY_BITS'(key_type_default(KEY_BITS)),
  parameter int                  STAGES   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_sin,
  input  logic             key_shift_en,
  input  logic             key_clear,
  output logic             key_armed,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] add1_i,
  input  logic [WIDTH-1:0] add2_i,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   result_o
);

  localparam int RW    = WIDTH + 1;
  localparam int IDX_W = $clog2(RW);

  logic [KEY_BITS-1:0] key_reg;
  logic [RW-1:0]       raw;
  logic [RW-1:0]       or_mask;
  logic [RW-1:0]       zero_mask;
  logic                accept;

  logic [STAGES-1:0]   vld;
  logic [RW-1:0]       dat   [STAGES];
  logic [RW-1:0]       nxt   [STAGES];
  logic                nxt_v [STAGES];
  logic                adv   [STAGES];

  key_loader #(
    .KEY_BITS (KEY_BITS)
  ) u_key_loader (
    .clk          (clk),
    .rst_n        (rst_n),
    .key_sin      (key_sin),
    .key_shift_en (key_shift_en),
    .key_clear    (key_clear),
    .key_reg      (key_reg),
    .key_armed    (key_armed)
  );

  // Unlocked arithmetic; for subtraction bit WIDTH is the no-borrow carry.
  always_comb begin
    if (op_sub) begin
      raw = {1'b0, add1_i} + {1'b0, ~add2_i} + RW'(1);
    end else begin
      raw = {1'b0, add1_i} + {1'b0, add2_i};
    end
  end

  // Build force-to-1 (wrong OR-type) and force-to-0 (wrong AND-type) masks.
  always_comb begin
    // NOTE: both masks get a full default before the loop, so no bit is left
    // unassigned on any path and no latch is inferred.
    or_mask   = '0;
    zero_mask = '0;
    for (int i = 0; i < KEY_BITS; i++) begin
      if (!KEY_TYPE[i] && key_reg[i]) begin
        or_mask[IDX_W'(tgt(i, WIDTH))] = 1'b1;
      end
      if (KEY_TYPE[i] && !key_reg[i]) begin
        zero_mask[IDX_W'(tgt(i, WIDTH))] = 1'b1;
      end
    end
  end

  assign accept   = in_valid & in_ready;
  assign in_ready = key_armed & adv[0] & ~key_clear;

  // Per-stage inputs and advance conditions; the last stage applies the gates.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [RW-1:0] pre;

    if (k == 0) begin : g_first
      assign pre      = raw;
      assign nxt_v[k] = accept;
    end else begin : g_inner
      assign pre      = dat[k-1];
      assign nxt_v[k] = vld[k-1];
    end

    if (k == STAGES - 1) begin : g_last
      // OR forcing first, then AND forcing, so a forced 0 wins a conflict.
      assign nxt[k] = (pre | or_mask) & ~zero_mask;
      assign adv[k] = ~vld[k] | out_ready;
    end else begin : g_pass
      assign nxt[k] = pre;
      assign adv[k] = ~vld[k] | adv[k+1];
    end
  end

  // Pipeline registers: a stage loads when it advances; clear drops all valids.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the data registers are reset as well as the valids, so result_o
    // reads 0 out of reset instead of an unknown value.
    if (!rst_n) begin
      vld <= '0;
      for (int k = 0; k < STAGES; k++) begin
        dat[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (adv[k]) begin
          dat[k] <= nxt[k];
        end
        if (key_clear) begin
          vld[k] <= 1'b0;
        end else if (adv[k]) begin
          vld[k] <= nxt_v[k];
        end
      end
    end
  end

  assign out_valid = vld[STAGES-1];
  assign result_o  = dat[STAGES-1];

endmodule

// File: tb/tb_locked_pipelined_addsub.sv
// Directed self-checking bench for locked_pipelined_addsub with WIDTH=8,
// KEY_BITS=16, KEY_TYPE=16'hAAAA, STAGES=2. Inputs change and outputs are
// sampled on the falling clock edge.
module tb_locked_pipelined_addsub;

  logic       clk;
  logic       rst_n;
  logic       key_sin;
  logic       key_shift_en;
  logic       key_clear;
  logic       key_armed;
  logic       in_valid;
  logic       in_ready;
  logic       op_sub;
  logic [7:0] add1_i;
  logic [7:0] add2_i;
  logic       out_valid;
  logic       out_ready;
  logic [8:0] result_o;

  int tests  = 0;
  int failed = 0;

  locked_pipelined_addsub #(
    .WIDTH    (8),
    .KEY_BITS (16),
    .KEY_TYPE (16'hAAAA),
    .STAGES   (2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .key_sin      (key_sin),
    .key_shift_en (key_shift_en),
    .key_clear    (key_clear),
    .key_armed    (key_armed),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .op_sub       (op_sub),
    .add1_i       (add1_i),
    .add2_i       (add2_i),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .result_o     (result_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    assert (observed === expected) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Shift a full 16-bit key in, LSB first, leaving the bench on a falling edge.
  task automatic load_key(input logic [15:0] k);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      key_shift_en = 1'b1;
      key_sin      = k[i];
    end
    @(negedge clk);
    key_shift_en = 1'b0;
    key_sin      = 1'b0;
  endtask

  // One-cycle key_clear pulse.
  task automatic pulse_clear();
    @(negedge clk);
    key_clear = 1'b1;
    @(negedge clk);
    key_clear = 1'b0;
  endtask

  // Single operation with out_ready high; checks acceptance, 2-cycle latency
  // and the result value.
  task automatic do_op(input string tag, input logic sub, input logic [7:0] a,
                       input logic [7:0] b, input logic [8:0] exp);
    @(negedge clk);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    op_sub   = sub;
    add1_i   = a;
    add2_i   = b;
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, "_valid_early"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_result"}, 32'(result_o), 32'(exp));
  endtask

  initial begin
    rst_n        = 1'b0;
    key_sin      = 1'b0;
    key_shift_en = 1'b0;
    key_clear    = 1'b0;
    in_valid     = 1'b0;
    op_sub       = 1'b0;
    add1_i       = '0;
    add2_i       = '0;
    out_ready    = 1'b1;

    // Reset state.
    #12;
    check("rst_key_armed", 32'(key_armed), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", 32'(result_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Load correct key 16'hAAAA, checking the state after 15 shifts.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i == 15) begin
        check("arm15_key_armed", 32'(key_armed), 32'd0);
        check("arm15_in_ready", 32'(in_ready), 32'd0);
      end
      key_shift_en = 1'b1;
      key_sin      = i[0];
    end
    @(negedge clk);
    key_shift_en = 1'b0;
    check("arm16_key_armed", 32'(key_armed), 32'd1);
    check("arm16_in_ready", 32'(in_ready), 32'd1);

    // Shifting while armed must not disturb the key.
    key_shift_en = 1'b1;
    key_sin      = 1'b1;
    @(negedge clk);
    key_shift_en = 1'b0;
    key_sin      = 1'b0;

    // Correct key: carry-out and subtraction with and without borrow.
    do_op("add_ff_01", 1'b0, 8'hFF, 8'h01, 9'h100);
    do_op("sub_5_7", 1'b1, 8'h05, 8'h07, 9'h0FE);
    do_op("sub_7_5", 1'b1, 8'h07, 8'h05, 9'h102);

    // Wrong key: bit 0 is an OR-type gate set to 1, forcing sum bit 0 high.
    pulse_clear();
    check("clr_key_armed", 32'(key_armed), 32'd0);
    load_key(16'hAAAB);
    check("wrong_key_armed", 32'(key_armed), 32'd1);
    do_op("wk_add_2_2", 1'b0, 8'h02, 8'h02, 9'h005);
    do_op("wk_add_3_4", 1'b0, 8'h03, 8'h04, 9'h007);

    // Back to the correct key for the streaming tests.
    pulse_clear();
    load_key(16'hAAAA);

    // Stream of 4 adds with a 3-cycle output stall after the first result.
    @(negedge clk);
    in_valid = 1'b1;
    op_sub   = 1'b0;
    add1_i   = 8'h01;
    add2_i   = 8'h01;
    @(negedge clk);
    check("strm_ready_b", 32'(in_ready), 32'd1);
    add1_i = 8'h02;
    add2_i = 8'h03;
    @(negedge clk);
    check("strm_a_valid", 32'(out_valid), 32'd1);
    check("strm_a_result", 32'(result_o), 32'h002);
    out_ready = 1'b0;
    add1_i    = 8'h10;
    add2_i    = 8'h20;
    #1;
    check("stall_ready_0", 32'(in_ready), 32'd0);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      check($sformatf("stall%0d_valid", c), 32'(out_valid), 32'd1);
      check($sformatf("stall%0d_result", c), 32'(result_o), 32'h002);
      check($sformatf("stall%0d_ready", c), 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    #1;
    check("unstall_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    check("strm_b_valid", 32'(out_valid), 32'd1);
    check("strm_b_result", 32'(result_o), 32'h005);
    add1_i = 8'hFF;
    add2_i = 8'hFF;
    @(negedge clk);
    in_valid = 1'b0;
    check("strm_c_result", 32'(result_o), 32'h030);
    @(negedge clk);
    check("strm_d_valid", 32'(out_valid), 32'd1);
    check("strm_d_result", 32'(result_o), 32'h1FE);
    @(negedge clk);
    check("strm_drained", 32'(out_valid), 32'd0);

    // key_clear with two results in flight drops both.
    in_valid = 1'b1;
    add1_i   = 8'h11;
    add2_i   = 8'h22;
    @(negedge clk);
    add1_i = 8'h33;
    add2_i = 8'h44;
    @(negedge clk);
    check("flight_valid", 32'(out_valid), 32'd1);
    key_clear = 1'b1;
    #1;
    check("clr_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    key_clear = 1'b0;
    check("clr_out_valid", 32'(out_valid), 32'd0);
    check("clr_armed", 32'(key_armed), 32'd0);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      check($sformatf("clr_idle%0d_valid", c), 32'(out_valid), 32'd0);
      check($sformatf("clr_idle%0d_ready", c), 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;

    // Reloading the key restores normal operation.
    load_key(16'hAAAA);
    do_op("reload_sub_0_1", 1'b1, 8'h00, 8'h01, 9'h0FF);

    // Asynchronous reset mid-operation clears everything.
    @(negedge clk);
    in_valid = 1'b1;
    add1_i   = 8'h01;
    add2_i   = 8'h02;
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_key_armed", 32'(key_armed), 32'd0);
    check("arst_result", 32'(result_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
